// File: rtl/store_buffer.sv
// Committed-store FIFO ahead of the dcache: in-order drain plus same-word load conflict/forward.
// Optional merge into the youngest entry when STORE_BUFFER_MERGE_EN is defined.
module store_buffer #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_reset_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [29:0]      enq_address_i,
  input  logic [31:0]      enq_data_i,
  input  logic [3:0]       enq_bm_i,
  output logic             store_valid_o,
  output logic [29:0]      store_address_o,
  output logic [31:0]      store_data_o,
  output logic [3:0]       store_bm_o,
  input  logic             cache_done_i,
  input  logic [29:0]      ld_check_address_i,
  input  logic [3:0]       ld_check_bm_i,
  output logic             ld_conflict_o,
  output logic             ld_forward_valid_o,
  output logic [31:0]      ld_forward_data_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  typedef enum logic {StIdle, StDrain} state_t;

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  state_t           r_state, w_state_next;
  logic [29:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [3:0]       r_bm   [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;

  logic w_merge_possible, w_enq, w_alloc, w_pop;

`ifdef STORE_BUFFER_MERGE_EN
  logic [PTR_W-1:0] w_young;
  logic [31:0]      w_merge_data;
  logic             w_do_merge;

  assign w_young = r_tail - PTR_W'(1);
  // Never merge into the entry the dcache is currently holding.
  assign w_merge_possible = (r_count != '0) && (r_addr[w_young] == enq_address_i) &&
                            !((r_state == StDrain) && (r_count == (PTR_W + 1)'(1)));
  assign w_do_merge = w_enq & w_merge_possible;

  always_comb begin
    w_merge_data = r_data[w_young];
    for (int b = 0; b < 4; b++) begin
      if (enq_bm_i[b]) w_merge_data[8*b +: 8] = enq_data_i[8*b +: 8];
    end
  end
`else
  assign w_merge_possible = 1'b0;
`endif

  assign enq_ready_o = (r_count != FullCount) | w_merge_possible;
  assign w_enq       = enq_valid_i & enq_ready_o;
  assign w_alloc     = w_enq & ~w_merge_possible;
  assign w_pop       = (r_state == StDrain) & cache_done_i;

  always_ff @(posedge cpu_clock_i) begin
    if (w_alloc) begin
      r_addr[r_tail] <= enq_address_i;
      r_data[r_tail] <= enq_data_i;
      r_bm[r_tail]   <= enq_bm_i;
    end
`ifdef STORE_BUFFER_MERGE_EN
    else if (w_do_merge) begin
      r_data[w_young] <= w_merge_data;
      r_bm[w_young]   <= r_bm[w_young] | enq_bm_i;
    end
`endif
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      r_state <= StIdle;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_alloc) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)   r_head <= r_head + PTR_W'(1);
      r_count <= r_count + (PTR_W + 1)'(w_alloc) - (PTR_W + 1)'(w_pop);
    end
  end

  // Drop back to idle after each completion so the dcache sees valid low before the next issue.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (r_count != '0) w_state_next = StDrain;
      StDrain: if (cache_done_i) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign store_valid_o   = (r_state == StDrain);
  assign store_address_o = r_addr[r_head];
  assign store_data_o    = r_data[r_head];
  assign store_bm_o      = r_bm[r_head];
  assign empty_o         = (r_count == '0) && (r_state == StIdle);
  assign count_o         = r_count;

  logic             w_conflict;
  logic [3:0]       w_hit_bm;
  logic [31:0]      w_hit_data;
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest; the last hit wins, giving the youngest match.
  always_comb begin
    w_conflict = 1'b0;
    w_hit_bm   = '0;
    w_hit_data = '0;
    w_idx      = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (((PTR_W + 1)'(k) < r_count) && (r_addr[w_idx] == ld_check_address_i) &&
          ((r_bm[w_idx] & ld_check_bm_i) != 4'b0)) begin
        w_conflict = 1'b1;
        w_hit_bm   = r_bm[w_idx];
        w_hit_data = r_data[w_idx];
      end
    end
  end

  assign ld_conflict_o      = w_conflict;
  assign ld_forward_valid_o = w_conflict && ((w_hit_bm & ld_check_bm_i) == ld_check_bm_i);
  assign ld_forward_data_o  = w_hit_data;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO of retired (committed) stores sitting directly upstream of the data cache.
- Accepts one committed store per cycle from the commit stage and drains entries oldest-first into the dcache store port, one at a time.
- Each drain holds the store stable until the dcache pulses its completion.
- Also gives the load pipeline a same-word conflict/forward lookup so loads never read stale memory.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- cpu_clock_i  in  1  core clock
- cpu_reset_i  in  1  asynchronous active-high reset
- enq_valid_i  in  1  committed store present
- enq_ready_o  out  1  entry available
- enq_address_i  in  30  word address (byte address [31:2])
- enq_data_i  in  32  lane-aligned store data
- enq_bm_i  in  4  byte mask
- store_valid_o  out  1  store request to dcache
- store_address_o  out  30  head entry word address
- store_data_o  out  32  head entry data
- store_bm_o  out  4  head entry byte mask
- cache_done_i  in  1  single-cycle dcache completion pulse
- ld_check_address_i  in  30  load word address
- ld_check_bm_i  in  4  load byte mask
- ld_conflict_o  out  1  any valid entry overlaps the load bytes
- ld_forward_valid_o  out  1  youngest overlapping entry covers every load byte
- ld_forward_data_o  out  32  data of that youngest entry
- empty_o  out  1  no entries and no drain in flight (used by fences)
- count_o  out  PTR_W+1  occupancy

Behaviour:
- Reset (async, active-high): head=tail=0, count=0, state=IDLE; store_valid_o=0, enq_ready_o=1, empty_o=1, ld_conflict_o=0, ld_forward_valid_o=0.
- Entry RAM contents are don't-care after reset.
- Storage: circular array with head/tail pointers of PTR_W bits; count tracked separately; pointers wrap DEPTH-1 -> 0.
- Enqueue: enq_valid_i & enq_ready_o writes at tail on the clock edge; tail++, count++.
- enq_ready_o = (count != DEPTH), purely combinational from count.
- Drain FSM, IDLE:
  - If count != 0, go to DRAIN next cycle.
  - store_valid_o = 0.
- Drain FSM, DRAIN:
  - store_valid_o = 1; store_address_o/store_data_o/store_bm_o driven from the head entry and held stable.
  - On cache_done_i: head++, count--, return to IDLE.
  - store_valid_o must therefore be low for at least one cycle after cache_done_i; the dcache re-samples store_valid_i in its idle cycle, so this prevents a double issue.
- Minimum issue spacing is 3 cycles per store: DRAIN, done, IDLE.
- cache_done_i outside DRAIN is ignored. The bench flags it as an error.
- Simultaneous enqueue and pop in the same cycle: count unchanged, both pointers advance.
  - A full buffer does not accept an enqueue in the pop cycle, because enq_ready_o is based on pre-pop count.
- The head entry is never overwritten while in DRAIN.
- Load check (combinational, zero latency):
  - An entry matches when it is valid, its address equals ld_check_address_i, and (bm & ld_check_bm_i) != 0.
  - ld_conflict_o = OR of all matches.
  - Youngest match is selected by age relative to tail.
  - ld_forward_valid_o = youngest match exists and (its bm & ld_check_bm_i) == ld_check_bm_i.
  - ld_forward_data_o = youngest match data; it is 0 when there is no match.
  - The entry currently in DRAIN still counts as valid until popped.
- empty_o = (count == 0) & (state == IDLE).
- Reset mid-drain: the buffer empties immediately and store_valid_o drops asynchronously. Lost stores are acceptable only because reset also resets the core.

Optional Feature:
- Macro: STORE_BUFFER_MERGE_EN.
- Defined: an enqueue whose address equals the youngest entry's address merges into that entry instead of allocating. Conditions: count != 0, and the youngest entry is not the head while in DRAIN.
  - Merge rule: data bytes are replaced where enq_bm_i is set; bm = old | new.
  - tail and count are unchanged.
  - A merge is accepted even when full, so enq_ready_o = (count != DEPTH) | merge_possible.
- Undefined: no merging; every enqueue allocates.

Test Plan:
- Reset, enqueue {addr 0x0000100, data 0xDEADBEEF, bm 0xF}:
  - store_valid_o rises 2 cycles after the enqueue edge with those values.
  - Pulse cache_done_i: store_valid_o low the next cycle, empty_o=1.
- Enqueue 8 stores back-to-back with cache_done_i withheld:
  - enq_ready_o=0 after the 8th and count_o=8.
  - A 9th enqueue is held off.
  - Pulse done 8 times: outputs appear in FIFO order and pointers wrap correctly.
- Enqueue {0x40, 0x11223344, 0xF}, then {0x40, 0x0000AA00, 0x2}; check {0x40, 0x2}:
  - ld_forward_valid_o=1, ld_forward_data_o=0x0000AA00.
  - Check bm 0xF: ld_conflict_o=1, ld_forward_valid_o=0.
- Enqueue and cache_done_i in the same cycle with count=3: count stays 3; the next drain presents the former head+1.
- Assert cpu_reset_i while in DRAIN with 4 entries: store_valid_o=0 asynchronously, count_o=0, empty_o=1.
- With STORE_BUFFER_MERGE_EN: {0x80, 0x000000FF, 0x1} then {0x80, 0x0000EE00, 0x2} while head is in DRAIN on another address: count stays 2 and the drained entry is {0x80, 0x0000EEFF, 0x3}. Without the macro: count becomes 3.
